// File: rtl/aes_key_schedule_iter_pkg.sv
// aes_key_schedule_iter_pkg: shared types, key-size helpers, AES S-box and round constants.
// The S-box is computed as a GF(2^8) inverse plus affine map instead of a 256-entry table.
package aes_key_schedule_iter_pkg;
   typedef logic [127:0] block_t;
   typedef logic [31:0] word_t;

   function automatic int nk_of(int key_bits);
      return key_bits / 32;
   endfunction

   function automatic int nr_of(int key_bits);
      return key_bits / 32 + 6;
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse (and maps 0 to 0)
   function automatic logic [7:0] aes_sbox(logic [7:0] x);
      logic [7:0] s, r;
      s = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] round_const(logic [3:0] i);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < 10; k++) r = (4'(k) < i) ? xtime(r) : r;
      return r;
   endfunction
endpackage

// File: rtl/aes_key_schedule_iter_if.sv
// aes_key_schedule_iter_if: key-load and round-key output handshake bundle.
interface aes_key_schedule_iter_if #(parameter int KEY_BITS = 256);
   logic                i_valid;
   logic                o_ready;
   logic [KEY_BITS-1:0] i_key;
   logic                o_valid;
   logic                i_ready;
   logic [127:0]        o_round_key;
   logic [3:0]          o_round_idx;
   logic                o_done;

   modport master (
      output i_valid, i_key, i_ready,
      input  o_ready, o_valid, o_round_key, o_round_idx, o_done
   );

   modport slave (
      input  i_valid, i_key, i_ready,
      output o_ready, o_valid, o_round_key, o_round_idx, o_done
   );
endinterface

// File: rtl/aes_key_schedule_iter_ks_word_gen.sv
// aes_key_schedule_iter_ks_word_gen: combinational next schedule word w[j] from w[j-1] and w[j-NK].
module aes_key_schedule_iter_ks_word_gen
   import aes_key_schedule_iter_pkg::*;
#(
   parameter int NK = 8
) (
   input  word_t      w_prev,
   input  word_t      w_nk,
   input  logic [2:0] jmod,
   input  logic [7:0] rcon,
   output word_t      w_new
);
   word_t sin, sub, t;

   always_comb begin
      sin   = jmod == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      sub   = {aes_sbox(sin[31:24]), aes_sbox(sin[23:16]), aes_sbox(sin[15:8]), aes_sbox(sin[7:0])};
      t     = jmod == 3'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && jmod == 3'd4) ? sub : w_prev;
      w_new = w_nk ^ t;
   end
endmodule

// File: rtl/aes_key_schedule_iter.sv
// aes_key_schedule_iter: iterative AES-128/192/256 key schedule, one word per cycle, one round key per transfer.
// AES_KS_STORE_EN adds a readable (NR+1) x 128 round-key store with ports i_rd_idx/o_rd_key.
module aes_key_schedule_iter
   import aes_key_schedule_iter_pkg::*;
#(
   parameter int KEY_BITS = 256
) (
   input  logic                    clock,
   input  logic                    reset_n,
   aes_key_schedule_iter_if.slave  bus
`ifdef AES_KS_STORE_EN
   ,
   input  logic [3:0]              i_rd_idx,
   output logic [127:0]            o_rd_key
`endif
);
   localparam int NK = nk_of(KEY_BITS);
   localparam int NR = nr_of(KEY_BITS);
   localparam int NW = 4 * (NR + 1);

   typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

   state_t           state;
   logic [NK*32-1:0] win;
   logic [5:0]       j;
   logic [2:0]       jmod;
   logic [3:0]       q;
   logic [3:0]       rcnt;
   block_t           asm_q;
   logic [2:0]       acnt;
   word_t            gen_word, new_word;
   block_t           xfer_key;
   logic             load, can_take, stall, prod, xfer, last_acc;
`ifdef AES_KS_STORE_EN
   block_t           store [NR+1];
`endif

   if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
      $fatal(1, "aes_key_schedule_iter: KEY_BITS must be 128, 192 or 256");
   end

   aes_key_schedule_iter_ks_word_gen #(.NK(NK)) u_word_gen (
      .w_prev (win[31:0]),
      .w_nk   (win[NK*32-1 -: 32]),
      .jmod   (jmod),
      .rcon   (round_const(q)),
      .w_new  (gen_word)
   );

   // The window rotates the key words through for j<NK so it then holds w[j-NK..j-1]
   always_comb begin
      load     = bus.i_valid && bus.o_ready;
      can_take = !bus.o_valid || bus.i_ready;
      stall    = acnt == 3'd4 && !can_take;
      prod     = state == EXPAND && !stall;
      new_word = j < 6'(NK) ? win[NK*32-1 -: 32] : gen_word;
      xfer     = can_take && (acnt == 3'd4 || (prod && acnt == 3'd3));
      xfer_key = acnt == 3'd4 ? asm_q : {asm_q[95:0], new_word};
      last_acc = state == DRAIN && bus.o_valid && bus.i_ready && bus.o_round_idx == 4'(NR);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         win             <= '0;
         j               <= '0;
         jmod            <= '0;
         q               <= '0;
         rcnt            <= '0;
         asm_q           <= '0;
         acnt            <= '0;
         bus.o_ready     <= 1'b0;
         bus.o_valid     <= 1'b0;
         bus.o_round_key <= '0;
         bus.o_round_idx <= '0;
         bus.o_done      <= 1'b0;
`ifdef AES_KS_STORE_EN
         for (int i = 0; i <= NR; i++) store[i] <= '0;
         o_rd_key        <= '0;
`endif
      end else begin
         bus.o_done  <= last_acc;
         bus.o_ready <= last_acc || (state == IDLE && !load);
         if (load) begin
            state <= EXPAND;
            win   <= bus.i_key;
            j     <= '0;
            jmod  <= '0;
            q     <= '0;
            rcnt  <= '0;
            acnt  <= '0;
         end
         if (prod) begin
            win   <= {win[NK*32-33:0], new_word};
            j     <= j + 6'd1;
            jmod  <= jmod == 3'(NK - 1) ? 3'd0 : jmod + 3'd1;
            q     <= jmod == 3'(NK - 1) ? q + 4'd1 : q;
            asm_q <= {asm_q[95:0], new_word};
            if (j == 6'(NW - 1)) state <= DRAIN;
         end
         if (xfer) acnt <= {2'b0, prod && acnt == 3'd4};
         else if (prod) acnt <= acnt + 3'd1;
         if (xfer) begin
            bus.o_valid     <= 1'b1;
            bus.o_round_key <= xfer_key;
            bus.o_round_idx <= rcnt;
            rcnt            <= rcnt + 4'd1;
         end else if (bus.i_ready) begin
            bus.o_valid     <= 1'b0;
         end
         if (last_acc) state <= IDLE;
`ifdef AES_KS_STORE_EN
         if (xfer) store[rcnt] <= xfer_key;
         o_rd_key <= i_rd_idx <= 4'(NR) ? store[i_rd_idx] : '0;
`endif
      end
   end
endmodule
